// File: rtl/counter_top_pkg.sv
// Shared defaults and sizing helper for the counter_top demo block.
package counter_top_pkg;

    localparam int CT_WIDTH     = 4;
    localparam int CT_MAX_VAL   = 15;
    localparam int CT_DIV_COUNT = 1;

    // Bits needed to represent values 0..value-1 (never less than one).
    function automatic int ct_clog2(input longint unsigned value);
        longint unsigned v;
        int              bits;
        bits = 0;
        v    = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/counter_top_tick_gen.sv
// Prescaler: one-cycle tick every DIV_COUNT clocks, forced low while in reset.
module tick_gen
    import counter_top_pkg::*;
#(
    parameter int DIV_COUNT = CT_DIV_COUNT,
    parameter int DIV_WIDTH = ct_clog2(longint'(DIV_COUNT) + 1)
) (
    input  logic clk,
    input  logic rs,
    output logic tick
);

    logic [DIV_WIDTH-1:0] div_cnt;

    // Gated by rs so the tick reads 0 during reset even when DIV_COUNT is 1.
    assign tick = rs && (div_cnt == DIV_WIDTH'(DIV_COUNT - 1));

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_top.sv
// Free-running up counter wrapping at MAX_VAL, advanced by a prescaler tick.
module counter_top
    import counter_top_pkg::*;
#(
    parameter int WIDTH     = CT_WIDTH,
    parameter int MAX_VAL   = CT_MAX_VAL,
    parameter int DIV_COUNT = CT_DIV_COUNT,
    parameter int DIV_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rs,
    output logic [WIDTH-1:0] q
);

    logic tick;

    tick_gen #(
        .DIV_COUNT (DIV_COUNT),
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_gen (
        .clk  (clk),
        .rs   (rs),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            q <= '0;
        end else if (tick) begin
            if (q == WIDTH'(MAX_VAL)) begin
                q <= '0;
            end else begin
                q <= q + WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_counter_top.sv
// Directed bench for counter_top: three configurations share one clock and reset.
module tb_counter_top;

    logic       clk;
    logic       rs;
    logic [3:0] q_d1;
    logic [3:0] q_d4;
    logic [3:0] q_m9;

    int checks;
    int errors;
    int n;

    counter_top #(
        .WIDTH     (4),
        .MAX_VAL   (15),
        .DIV_COUNT (1),
        .DIV_WIDTH (32)
    ) u_d1 (
        .clk (clk),
        .rs  (rs),
        .q   (q_d1)
    );

    counter_top #(
        .WIDTH     (4),
        .MAX_VAL   (15),
        .DIV_COUNT (4),
        .DIV_WIDTH (32)
    ) u_d4 (
        .clk (clk),
        .rs  (rs),
        .q   (q_d4)
    );

    counter_top #(
        .WIDTH     (4),
        .MAX_VAL   (9),
        .DIV_COUNT (1),
        .DIV_WIDTH (32)
    ) u_m9 (
        .clk (clk),
        .rs  (rs),
        .q   (q_m9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks = checks + 1;
        if (observed != expected) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_d1"}, int'(q_d1), 0);
        check({tag, "_d4"}, int'(q_d4), 0);
        check({tag, "_m9"}, int'(q_m9), 0);
    endtask

    // Advance one edge and compare against hand-derived sequences for n edges since reset release.
    task automatic step;
        @(posedge clk);
        #1;
        n = n + 1;
        check($sformatf("d1_edge%0d", n), int'(q_d1), n % 16);
        check($sformatf("d4_edge%0d", n), int'(q_d4), (n / 4) % 16);
        check($sformatf("m9_edge%0d", n), int'(q_m9), n % 10);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n      = 0;
        rs     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");

        @(negedge clk);
        rs = 1'b1;
        n  = 0;
        // Covers q=1,2,3 start, prescaler steps at edges 4/8, wrap 9->0 and 15->0.
        for (int i = 0; i < 25; i++) step();

        check("d1_at_nine", int'(q_d1), 9);
        #2;
        rs = 1'b0;
        #1;
        check_all_zero("async_mid");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all_zero("held_reset");
        end

        @(negedge clk);
        rs = 1'b1;
        n  = 0;
        for (int i = 0; i < 5; i++) step();

        check("d1_at_five", int'(q_d1), 5);
        #2;
        rs = 1'b0;
        #1;
        check_all_zero("glitch_low");
        rs = 1'b1;
        #1;
        check_all_zero("glitch_after");
        n = 0;
        for (int i = 0; i < 3; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
